// File: rtl/sbox_sched_pkg.sv
// Shared types and the byte-substitution function used by the sbox scheduler.
// The S-box is computed as GF(2^8) inverse (x^254) followed by the AES affine map.
package sbox_sched_pkg;
  typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} sched_state_t;
  typedef enum logic {GRANT_STATE, GRANT_KEY} grant_t;

  localparam int ST_BYTES = 16;
  localparam int KW_BYTES = 4;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/sbox_lane_array.sv
// One SBox cell per byte lane; purely combinational, lanes packed LSB-first.
module sbox_cell
  import sbox_sched_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox_byte(a);
endmodule

module sbox_lane_array #(
  parameter int LANES = 4
) (
  input  logic [LANES*8-1:0] lane_in,
  output logic [LANES*8-1:0] lane_out
);
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox_cell u_cell (.a(lane_in[8*j +: 8]), .y(lane_out[8*j +: 8]));
  end
endmodule

// File: rtl/sbox_scheduler.sv
// Time-multiplexes LANES S-box lanes between state SubBytes and key SubWord jobs,
// round-robin arbitrated, one job in flight, results published with a done pulse.
module sbox_scheduler
  import sbox_sched_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_data_in,
  output logic         st_done,
  output logic [127:0] st_data_out,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_word_in,
  output logic         kw_done,
  output logic [31:0]  kw_word_out
);
  localparam int ST_BEATS = ST_BYTES / LANES;
  localparam int KW_BEATS = (LANES >= KW_BYTES) ? 1 : KW_BYTES / LANES;
  localparam int BW       = (ST_BEATS > 1) ? $clog2(ST_BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sbox_scheduler: LANES must be 1, 2, 4, 8 or 16");
  end

  sched_state_t                 state, state_nxt;
  grant_t                       last_grant;
  logic [BW-1:0]                beat;
  logic [0:ST_BYTES-1][7:0]     st_buf, st_sh, st_sh_nxt;
  logic [0:KW_BYTES-1][7:0]     kw_buf, kw_sh, kw_sh_nxt;
  logic [LANES-1:0][7:0]        lane_in, lane_out;
  logic                         st_acc, kw_acc, last_beat;

  sbox_lane_array #(.LANES(LANES)) u_lanes (.lane_in(lane_in), .lane_out(lane_out));

  assign st_acc = st_valid && st_ready;
  assign kw_acc = kw_valid && kw_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    st_ready  = 1'b0;
    kw_ready  = 1'b0;
    last_beat = (state == KW_RUN) ? (beat == BW'(KW_BEATS - 1)) : (beat == BW'(ST_BEATS - 1));
    case (state)
      IDLE: begin
        kw_ready = !st_valid || last_grant == GRANT_STATE;
        st_ready = !kw_valid || last_grant == GRANT_KEY;
        if (kw_valid && kw_ready)      state_nxt = KW_RUN;
        else if (st_valid && st_ready) state_nxt = ST_RUN;
      end
      ST_RUN, KW_RUN: if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane steering: lane j of beat b handles byte b*LANES+j of the active job
  always_comb begin
    logic [3:0] si;
    logic [1:0] ki;
    lane_in   = '0;
    st_sh_nxt = st_sh;
    kw_sh_nxt = kw_sh;
    for (int j = 0; j < LANES; j++) begin
      si = 4'(int'(beat) * LANES + j);
      ki = 2'(int'(beat) * LANES + j);
      if (state == KW_RUN) begin
        if (j < KW_BYTES) begin
          lane_in[j]    = kw_buf[ki];
          kw_sh_nxt[ki] = lane_out[j];
        end
      end else begin
        lane_in[j] = st_buf[si];
        if (state == ST_RUN) st_sh_nxt[si] = lane_out[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat        <= '0;
      last_grant  <= GRANT_STATE;
      st_buf      <= '0;
      kw_buf      <= '0;
      st_sh       <= '0;
      kw_sh       <= '0;
      st_data_out <= '0;
      kw_word_out <= '0;
      st_done     <= 1'b0;
      kw_done     <= 1'b0;
    end else begin
      st_done <= 1'b0;
      kw_done <= 1'b0;
      if (state == IDLE) begin
        beat <= '0;
        if (kw_acc) begin
          kw_buf     <= kw_word_in;
          last_grant <= GRANT_KEY;
        end else if (st_acc) begin
          st_buf     <= st_data_in;
          last_grant <= GRANT_STATE;
        end
      end else begin
        beat  <= beat + 1'b1;
        st_sh <= st_sh_nxt;
        kw_sh <= kw_sh_nxt;
        if (last_beat) begin
          if (state == ST_RUN) begin
            st_data_out <= st_sh_nxt;
            st_done     <= 1'b1;
          end else begin
            kw_word_out <= kw_sh_nxt;
            kw_done     <= 1'b1;
          end
        end
      end
    end
  end
endmodule
